// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default widths for the sequential arithmetic units.
package arith_pkg;
    localparam int DW_N = 16;
    localparam int DW_D = 8;
    typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_t;
endpackage

// File: rtl/divider_seq_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i  remainder from the previous step (always < b_i)
//   bit_i  next dividend bit, MSB first
//   b_i    divisor
//   rem_o  remainder after this step
//   q_o    quotient bit produced by this step
module div_step #(
    parameter int DW_D = arith_pkg::DW_D
) (
    input  logic [DW_D-1:0] rem_i,
    input  logic            bit_i,
    input  logic [DW_D-1:0] b_i,
    output logic [DW_D-1:0] rem_o,
    output logic            q_o
);
    import arith_pkg::*;
    logic [DW_D:0] rem_t;
    always_comb begin
        rem_t = {rem_i, bit_i};
        q_o   = rem_t >= {1'b0, b_i};
        // a successful subtract always lands below b, so DW_D bits hold it
        rem_o = DW_D'(q_o ? rem_t - {1'b0, b_i} : rem_t);
    end
endmodule

// File: rtl/divider_seq.sv
// divider_seq: unsigned sequential restoring divider, one quotient bit per clock.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   a_bi     dividend, sampled when start_i is accepted
//   b_bi     divisor, sampled when start_i is accepted
//   start_i  request, accepted only when idle
//   ready_o  idle, results valid and held
//   busy_o   working (always ~ready_o)
//   q_bo     quotient
//   r_bo     remainder
//   dbz_o    last completed operation divided by zero
module divider_seq #(
    parameter int DW_N = arith_pkg::DW_N,
    parameter int DW_D = arith_pkg::DW_D
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW_N-1:0] a_bi,
    input  logic [DW_D-1:0] b_bi,
    input  logic            start_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic [DW_N-1:0] q_bo,
    output logic [DW_D-1:0] r_bo,
    output logic            dbz_o
);
    import arith_pkg::*;
    localparam int CW = $clog2(DW_N);
    state_t          state_q, state_d;
    logic [CW-1:0]   ctr_q;
    logic [DW_N-1:0] dvd_q, q_q;
    logic [DW_D-1:0] rem_q, b_q, r_q, rem_nxt;
    logic            dbz_q, q_bit, last;
    div_step #(.DW_D(DW_D)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DW_N-1]),
        .b_i   (b_q),
        .rem_o (rem_nxt),
        .q_o   (q_bit)
    );
    assign last = ctr_q == CW'(DW_N - 1);
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (start_i ? WORK : IDLE) : (last ? IDLE : WORK);
    end
    always_comb begin
        ready_o = state_q == IDLE;
        busy_o  = state_q == WORK;
        q_bo    = q_q;
        r_bo    = r_q;
        dbz_o   = dbz_q;
    end
    // With b == 0 every step subtracts zero, so the plain datapath already
    // yields an all-ones quotient and the low dividend bits as remainder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_q <= '0;
            dvd_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                ctr_q <= '0;
                dvd_q <= a_bi;
                rem_q <= '0;
                b_q   <= b_bi;
            end
        end else begin
            ctr_q <= ctr_q + 1'b1;
            dvd_q <= {dvd_q[DW_N-2:0], q_bit};
            rem_q <= rem_nxt;
            if (last) begin
                q_q   <= {dvd_q[DW_N-2:0], q_bit};
                r_q   <= rem_nxt;
                dbz_q <= b_q == '0;
            end
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed and random checks of divider_seq against an arithmetic model.
module tb_divider_seq;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] a_bi = '0;
    logic [7:0]  b_bi = '0;
    logic        start_i = 1'b0;
    logic        ready_o, busy_o, dbz_o;
    logic [15:0] q_bo;
    logic [7:0]  r_bo;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] m_q = '0;
    logic [7:0]  m_r = '0;
    logic        m_dbz = 1'b0;

    divider_seq dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .dbz_o   (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // p1/p2: busy cycles (1..16) on which a stray start with a=1,b=1 is driven
    // rst_at: busy cycle on which reset is asserted (0 = never)
    task automatic op(input logic [15:0] a, input logic [7:0] b,
                      input int p1, input int p2, input int rst_at);
        int  n;
        bit  done;
        a_bi = a;
        b_bi = b;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_bi = 16'($urandom);
        b_bi = 8'($urandom);
        chk("busy_after_start", {31'd0, busy_o}, 1);
        chk("held_q", {16'd0, q_bo}, {16'd0, m_q});
        chk("held_r", {24'd0, r_bo}, {24'd0, m_r});
        chk("held_dbz", {31'd0, dbz_o}, {31'd0, m_dbz});
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            if (n + 1 == p1 || n + 1 == p2) begin
                start_i = 1'b1;
                a_bi = 16'd1;
                b_bi = 8'd1;
            end
            if (n + 1 == rst_at) rst_i = 1'b1;
            tick();
            n++;
            start_i = 1'b0;
            if (rst_i) begin
                rst_i = 1'b0;
                m_q = '0;
                m_r = '0;
                m_dbz = 1'b0;
                chk("abort_busy", {31'd0, busy_o}, 0);
                chk("abort_ready", {31'd0, ready_o}, 1);
                chk("abort_q", {16'd0, q_bo}, 0);
                chk("abort_r", {24'd0, r_bo}, 0);
                chk("abort_dbz", {31'd0, dbz_o}, 0);
                return;
            end
            chk("busy_not_ready", {31'd0, busy_o}, {31'd0, ~ready_o});
            done = ready_o;
        end
        chk("latency", n, 16);
        m_q = b == 0 ? 16'hFFFF : a / b;
        m_r = b == 0 ? a[7:0] : 8'(a % b);
        m_dbz = b == 0;
        chk("quotient", {16'd0, q_bo}, {16'd0, m_q});
        chk("remainder", {24'd0, r_bo}, {24'd0, m_r});
        chk("dbz", {31'd0, dbz_o}, {31'd0, m_dbz});
        if (!dbz_o)
            chk("invariant", {31'd0, (32'(q_bo) * 32'(b) + 32'(r_bo) == 32'(a)) && (r_bo < b)}, 1);
        if (p2 == 16) begin
            tick();
            chk("ignored_start_idle", {31'd0, ready_o}, 1);
            chk("ignored_start_q", {16'd0, q_bo}, {16'd0, m_q});
        end
    endtask

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_ready", {31'd0, ready_o}, 1);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_q", {16'd0, q_bo}, 0);
        chk("rst_r", {24'd0, r_bo}, 0);
        chk("rst_dbz", {31'd0, dbz_o}, 0);
        op(16'd200, 8'd7, 0, 0, 0);
        op(16'd65535, 8'd255, 0, 0, 0);
        op(16'd0, 8'd3, 0, 0, 0);
        op(16'd5, 8'd0, 0, 0, 0);
        op(16'd9, 8'd3, 0, 0, 0);
        op(16'd100, 8'd9, 3, 16, 0);
        op(16'd1000, 8'd3, 0, 0, 8);
        repeat (20) tick();
        chk("no_late_result_ready", {31'd0, ready_o}, 1);
        chk("no_late_result_q", {16'd0, q_bo}, 0);
        chk("no_late_result_r", {24'd0, r_bo}, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            op(a, b, 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
